// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//               request-to-send, shifts a command byte out on device clock
//               falls, checks the device ACK and guards with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES     = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err_ack,
  output logic       err_timeout
);

  localparam int c_INH_W = $clog2(CLK_INHIBIT_CYCLES + 1);
  localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [c_WD_W-1:0]  c_WD_MAX   = c_WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_RTS     = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2:0]           r_clk_sync;
  logic [1:0]           r_data_sync;
  logic [9:0]           r_shift;
  logic [3:0]           r_bit_cnt;
  logic [c_INH_W-1:0]   r_inh_cnt;
  logic [c_WD_W-1:0]    r_wdog;
  logic                 r_data_oe;
  logic                 w_fall;
  logic                 w_data_s;
  logic                 w_active;
  logic                 w_timeout;
  logic                 w_inh_last;
  logic                 w_done;
  logic                 w_err_ack;

  assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_data_s   = r_data_sync[1];
  assign w_active   = (r_state == S_RTS) || (r_state == S_SEND) ||
                      (r_state == S_ACK) || (r_state == S_RELEASE);
  assign w_timeout  = w_active && (r_wdog == c_WD_MAX);
  assign w_inh_last = (r_state == S_INHIBIT) && (r_inh_cnt == c_INH_LAST);

  // Clock is pulled low only while inhibiting; data is pulled low for the
  // start bit from the last inhibit cycle, then follows the frame bits.
  // A watchdog abort releases data in the same cycle it is flagged.
  assign ps2_clk_oe  = (r_state == S_INHIBIT);
  assign ps2_data_oe = w_inh_last |
                       (((r_state == S_RTS) || (r_state == S_SEND)) & r_data_oe & ~w_timeout);
  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = ~tx_ready;
  assign done        = w_done;
  assign err_ack     = w_err_ack;
  assign err_timeout = w_timeout;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and completion pulses; a watchdog expiry overrides everything
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_err_ack    = 1'b0;
    case (r_state)
      S_IDLE:    if (tx_valid) w_state_next = S_INHIBIT;
      S_INHIBIT: if (r_inh_cnt == c_INH_LAST) w_state_next = S_RTS;
      S_RTS:     if (w_fall) w_state_next = S_SEND;
      S_SEND:    if (w_fall && (r_bit_cnt == 4'd9)) w_state_next = S_ACK;
      S_ACK: begin
        if (w_fall) begin
          if (w_data_s) begin
            w_err_ack    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (r_clk_sync[1] && w_data_s) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default:   w_state_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_done       = 1'b0;
      w_err_ack    = 1'b0;
    end
  end

  // Pad synchronizers, frame shifter, inhibit counter and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 2'b11;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_inh_cnt   <= '0;
      r_wdog      <= '0;
      r_data_oe   <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};

      case (r_state)
        S_IDLE: begin
          r_data_oe <= 1'b0;
          r_bit_cnt <= '0;
          r_inh_cnt <= '0;
          if (tx_valid) r_shift <= {1'b1, ~^tx_data, tx_data};
        end
        S_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          if (w_inh_last) r_data_oe <= 1'b1;
        end
        S_RTS, S_SEND: begin
          // Open-drain: a 0 bit is driven low, a 1 bit releases the line
          if (w_fall) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[9:1]};
            r_bit_cnt <= (r_state == S_RTS) ? 4'd1 : (r_bit_cnt + 4'd1);
          end
        end
        default:   r_data_oe <= 1'b0;
      endcase

      // Watchdog restarts on entry to the active phase and on every fall
      if (!w_active || w_fall) begin
        r_wdog <= '0;
      end else if (r_wdog != c_WD_MAX) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed bench for ps2_host_tx with a PS/2 device model and a
//               bit scoreboard fed when each byte is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_w, ps2_data_w;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err_ack, err_timeout;

  int total = 0;
  int bad   = 0;

  // Monitor counters
  int   n_done = 0, n_eack = 0, n_eto = 0;
  int   run = 0, last_run = 0;
  int   ready_bad = 0, stab_bad = 0, excl_bad = 0;
  logic prev_done = 1'b0, prev_doe = 1'b0;

  bit   exp_q[$];

  assign ps2_clk_w  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_w = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_INHIBIT_CYCLES(10),
    .TIMEOUT_CYCLES    (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk_w),
    .ps2_data   (ps2_data_w),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err_ack    (err_ack),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counts, inhibit run length, ready/done ordering, data stability
  always @(negedge clk) begin
    if (done)        n_done <= n_done + 1;
    if (err_ack)     n_eack <= n_eack + 1;
    if (err_timeout) n_eto  <= n_eto + 1;
    if ((int'(done) + int'(err_ack) + int'(err_timeout)) > 1) excl_bad <= excl_bad + 1;
    run <= ps2_clk_oe ? run + 1 : 0;
    if (!ps2_clk_oe && run != 0) last_run <= run;
    if ((done && tx_ready) || (prev_done && !tx_ready)) ready_bad <= ready_bad + 1;
    prev_done <= done;
    if ((ps2_data_oe !== prev_doe) && ps2_clk_w && !err_timeout && !reset)
      stab_bad <= stab_bad + 1;
    prev_doe <= ps2_data_oe;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a byte and push the frame the device should see
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(~^b);
    exp_q.push_back(1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("ready_low_after_accept", tx_ready, 1'b0);
  endtask

  task automatic sample_bit(input int idx);
    bit e;
    if (exp_q.size() == 0) begin
      check($sformatf("sb_underflow%0d", idx), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("bit%0d", idx), ps2_data_w, e);
    end
  endtask

  // Device model: waits for inhibit + RTS, clocks n_falls bits, optional ACK
  task automatic dev_frame(input bit ack_ok, input int n_falls, output time t_fall);
    bit got;
    t_fall = 0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (ps2_clk_oe) begin got = 1; break; end
      @(negedge clk);
    end
    check("inhibit_seen", got, 1'b1);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe) begin got = 1; break; end
    end
    check("rts_seen", got, 1'b1);
    repeat (5) @(negedge clk);
    sample_bit(0);
    for (int k = 1; k <= n_falls; k++) begin
      dev_clk = 1'b0;
      t_fall  = $time;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      sample_bit(k);
      if (k < n_falls) repeat (HALF) @(negedge clk);
    end
    if (n_falls == 10) begin
      repeat (HALF) @(negedge clk);
      dev_data = ack_ok ? 1'b0 : 1'b1;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(input string tag);
    bit got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_ready) begin got = 1; break; end
    end
    check(tag, got, 1'b1);
  endtask

  initial begin
    int  d_done, d_eack, d_eto;
    time tf;
    bit  got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {done, err_ack, err_timeout}, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", tx_ready, 1'b1);

    // ED with ACK: frame, single done, 10-cycle inhibit
    d_done = n_done; d_eack = n_eack;
    send(8'hED);
    dev_frame(1'b1, 10, tf);
    wait_ready("ed_ready_back");
    check("ed_inhibit_len", last_run, 10);
    check("ed_done_cnt", n_done - d_done, 1);
    check("ed_eack_cnt", n_eack - d_eack, 0);
    check("ed_sb_empty", exp_q.size(), 0);

    // F4: parity 0, done pulse
    d_done = n_done;
    send(8'hF4);
    dev_frame(1'b1, 10, tf);
    wait_ready("f4_ready_back");
    check("f4_done_cnt", n_done - d_done, 1);
    check("f4_ready_order", ready_bad, 0);

    // NACK: data left high at fall 11
    d_done = n_done; d_eack = n_eack;
    send(8'hED);
    dev_frame(1'b0, 10, tf);
    wait_ready("nack_ready_back");
    check("nack_eack_cnt", n_eack - d_eack, 1);
    check("nack_done_cnt", n_done - d_done, 0);
    check("nack_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Device stops after fall 4: d3 of F4 is 0 so data is being driven
    d_eto = n_eto; d_done = n_done;
    send(8'hF4);
    dev_frame(1'b1, 4, tf);
    check("to_driving_before", ps2_data_oe, 1'b1);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err_timeout) begin got = 1; break; end
    end
    check("to_seen", got, 1'b1);
    // 3-cycle synchronizer latency to the detected fall, then 50 cycles
    check("to_latency", 32'(($time - tf) / 10), 53);
    check("to_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    check("to_idle", tx_ready, 1'b1);
    check("to_eto_cnt", n_eto - d_eto, 1);
    check("to_done_cnt", n_done - d_done, 0);
    exp_q.delete();

    // tx_valid held with 55 during ED transfer
    d_done = n_done;
    send(8'hED);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    dev_frame(1'b1, 10, tf);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
    check("hold_done_seen", got, 1'b1);
    @(negedge clk);
    check("hold_ready_returns", tx_ready, 1'b1);
    @(negedge clk);
    check("hold_55_accepted", tx_ready, 1'b0);
    tx_valid = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(tx_data[i]);
    exp_q.push_back(~^tx_data);
    exp_q.push_back(1'b1);
    dev_frame(1'b1, 10, tf);
    wait_ready("hold_55_ready_back");
    check("hold_done_cnt", n_done - d_done, 2);

    // Reset during SEND while d4 (0) is driven
    d_done = n_done; d_eack = n_eack; d_eto = n_eto;
    send(8'hED);
    dev_frame(1'b1, 5, tf);
    check("mid_driving", ps2_data_oe, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("mid_no_pulse", (n_done - d_done) + (n_eack - d_eack) + (n_eto - d_eto), 0);
    send(8'hED);
    dev_frame(1'b1, 10, tf);
    wait_ready("post_rst_ready_back");
    check("post_rst_done_cnt", n_done - d_done, 1);

    repeat (3) @(negedge clk);
    check("data_stable", stab_bad, 0);
    check("pulse_exclusive", excl_bad, 0);
    check("ready_done_order", ready_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_INHIBIT_CYCLES, default 5000, clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, max clk cycles between consecutive ps2_clk falling edges (and from request-to-send to first edge) before abort.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  PS/2 clock line as seen on the pad (asynchronous).
REQ-006 ps2_data  input  1  PS/2 data line as seen on the pad (asynchronous).
REQ-007 ps2_clk_oe  output  1  1 = drive PS/2 clock low, 0 = release (open-drain).
REQ-008 ps2_data_oe  output  1  1 = drive PS/2 data low, 0 = release (open-drain).
REQ-009 tx_data  input  8  command byte to send to device.
REQ-010 tx_valid  input  1  request to send tx_data; accepted when tx_valid & tx_ready on a clk edge.
REQ-011 tx_ready  output  1  high only in IDLE.
REQ-012 busy  output  1  high in every state except IDLE; receivers sharing the bus ignore traffic while high.
REQ-013 done  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-014 err_ack  output  1  one-cycle pulse: ps2_data high at ACK sample.
REQ-015 err_timeout  output  1  one-cycle pulse: watchdog expired.

Function
REQ-016 ps2_clk SHALL pass a 3-flop synchronizer; falling edge fall = sync[2] & ~sync[1]; ps2_data SHALL be 2-flop synchronized before sampling.
REQ-017 On accept, tx_data SHALL be latched into a shift register; frame = {stop=1, parity, d7..d0}, parity = ~^tx_data (odd).
REQ-018 States SHALL be IDLE, INHIBIT, RTS, SEND, ACK, RELEASE.
REQ-019 IDLE: both oe = 0; accept -> INHIBIT next cycle.
REQ-020 INHIBIT: ps2_clk_oe = 1 for exactly CLK_INHIBIT_CYCLES cycles; ps2_data_oe asserted in the last inhibit cycle; then -> RTS.
REQ-021 RTS: ps2_clk_oe = 0, ps2_data_oe = 1 (start bit); first fall -> drive d0, -> SEND, bit counter = 1.
REQ-022 SEND: on each fall, drive next frame bit (ps2_data_oe = ~bit), counter increments; falls 2..8 drive d1..d7, fall 9 parity, fall 10 stop (release); then -> ACK.
REQ-023 Data output SHALL change only in the clk cycle after a detected fall; stable otherwise.
REQ-024 ACK: both oe = 0; on next fall sample synchronized ps2_data: 0 -> RELEASE, 1 -> pulse err_ack, -> IDLE.
REQ-025 RELEASE: wait until synchronized ps2_clk and ps2_data both 1, then pulse done, -> IDLE.
REQ-026 Watchdog SHALL clear on entry to RTS and on every fall; if it reaches TIMEOUT_CYCLES in RTS/SEND/ACK/RELEASE: both oe = 0, pulse err_timeout, -> IDLE.
REQ-027 tx_valid while not tx_ready SHALL be ignored, no latch, no queueing.
REQ-028 done, err_ack, err_timeout SHALL be mutually exclusive, at most one per accepted byte.
REQ-029 Counters sized for the parameter values; watchdog saturates, no wrap.

Reset
REQ-030 reset SHALL asynchronously force IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1 (after deassert), busy = 0, done = err_ack = err_timeout = 0, counters and shift register 0.
REQ-031 Reset mid-frame SHALL release both lines within the reset assertion, no pulse emitted.

Verification
REQ-032 CLK_INHIBIT_CYCLES=10; send 8'hED, device model clocks 11 falls and ACKs -> bits sampled on rising edges 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done one pulse; clock held low exactly 10 cycles.
REQ-033 Send 8'hF4 -> parity bit 0; done pulses; tx_ready low from accept until cycle after done.
REQ-034 Device leaves data high at fall 11 -> err_ack one pulse, no done, lines released.
REQ-035 TIMEOUT_CYCLES=50, device stops clocking after fall 4 -> err_timeout at 50 cycles after fall 4, both oe = 0, IDLE.
REQ-036 tx_valid held high with 8'h55 during a transfer of 8'hED -> only ED sent; 55 accepted on the cycle tx_ready returns.
REQ-037 reset asserted during SEND bit 5 -> ps2_clk_oe = ps2_data_oe = 0 immediately; after deassert, a new 8'hED transfer completes with done.
